// File: rtl/gs_audio_pkg.sv
// Shared constants and sample conversion for the General Sound I2S output stage.
// The optional window averager is enabled with the GS_AUDIO_AVG_EN macro.
package gs_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam logic [8:0] MIDPOINT = 9'd256;

  // Offset-binary 9-bit GS sample to signed 16-bit PCM, left-justified.
  function automatic logic [SAMPLE_W-1:0] to_pcm16(input logic [8:0] sample);
    logic [9:0] s10;
    s10 = {1'b0, sample} - {1'b0, MIDPOINT};
    return {s10[8:0], 7'b000_0000};
  endfunction

endpackage

// File: rtl/gs_audio_avg.sv
// Boxcar averager over non-overlapping windows of 2^AVG_LOG2 clk_sys cycles.
// Instantiated per channel only when GS_AUDIO_AVG_EN is defined.
module gs_audio_avg
  import gs_audio_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic       clk_sys,
  input  logic       areset,
  input  logic [8:0] in_s,
  output logic [8:0] avg
);

  localparam int SUM_W = 9 + AVG_LOG2;

  logic [AVG_LOG2-1:0] win_cnt;
  logic [SUM_W-1:0]    acc;
  logic [SUM_W-1:0]    acc_next;

  assign acc_next = acc + SUM_W'(in_s);

  always_ff @(posedge clk_sys or posedge areset) begin
    if (areset) begin
      win_cnt <= '0;
      acc     <= '0;
      avg     <= MIDPOINT;
    end else begin
      win_cnt <= win_cnt + AVG_LOG2'(1);
      // The sample arriving on the last window cycle is folded into this window.
      if (&win_cnt) begin
        acc <= '0;
        avg <= acc_next[SUM_W-1:AVG_LOG2];
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/gs_audio_i2s.sv
// GS stereo output to Philips I2S: BCK/LRCK divider, 64-slot frame, indexed data.
// Define GS_AUDIO_AVG_EN to feed the frame latch from per-channel window averages.
module gs_audio_i2s
  import gs_audio_pkg::*;
#(
  parameter int BCLK_DIV = 14,
  parameter int AVG_LOG2 = 4
) (
  input  logic       clk_sys,
  input  logic       areset,
  input  logic [8:0] in_l,
  input  logic [8:0] in_r,
  input  logic       mute,
  output logic       i2s_bck,
  output logic       i2s_lrck,
  output logic       i2s_data,
  output logic       sample_strobe
);

  if (BCLK_DIV < 2 || BCLK_DIV > 255) begin : g_bad_bclk_div
    $error("gs_audio_i2s: BCLK_DIV must be in 2..255");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg_log2
    $error("gs_audio_i2s: AVG_LOG2 must be in 1..8");
  end

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]            div_cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic [8:0]            src_l;
  logic [8:0]            src_r;
  logic [SAMPLE_W-1:0]   pcm_l;
  logic [SAMPLE_W-1:0]   pcm_r;
  logic                  div_wrap;
  logic                  fall_evt;
  logic                  frame_wrap;
  logic [5:0]            bit_cnt_next;
  logic [5:0]            data_idx;

`ifdef GS_AUDIO_AVG_EN
  gs_audio_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_l (
    .clk_sys (clk_sys),
    .areset  (areset),
    .in_s    (in_l),
    .avg     (src_l)
  );
  gs_audio_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_r (
    .clk_sys (clk_sys),
    .areset  (areset),
    .in_s    (in_r),
    .avg     (src_r)
  );
`else
  assign src_l = in_l;
  assign src_r = in_r;
`endif

  always_comb begin
    pcm_l        = mute ? '0 : to_pcm16(src_l);
    pcm_r        = mute ? '0 : to_pcm16(src_r);
    div_wrap     = (div_cnt == DIV_LAST);
    fall_evt     = div_wrap && i2s_bck;
    frame_wrap   = fall_evt && (bit_cnt == 6'd63);
    bit_cnt_next = bit_cnt + 6'd1;
    // Slot k carries F[(64-k) mod 64]: the one-BCK I2S delay after LRCK changes.
    data_idx     = 6'd0 - bit_cnt_next;
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register sees the pre-edge value of its neighbours.
  always_ff @(posedge clk_sys or posedge areset) begin
    if (areset) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      // NOTE: frame is a flat 64-bit register, not a RAM, so it is reset with
      // the rest of the state and an aborted frame never leaks out after reset.
      frame         <= '0;
      i2s_bck       <= 1'b0;
      i2s_lrck      <= 1'b0;
      i2s_data      <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_wrap;

      if (div_wrap) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      // Data and LRCK move only on BCK falling edges, never on a rising edge.
      if (fall_evt) begin
        bit_cnt  <= bit_cnt_next;
        i2s_lrck <= bit_cnt_next[5];
        i2s_data <= frame[data_idx];
        if (bit_cnt == 6'd63) begin
          frame <= {pcm_l, (SLOT_BITS - SAMPLE_W)'(0), pcm_r, (SLOT_BITS - SAMPLE_W)'(0)};
        end
      end
    end
  end

endmodule

// File: tb/tb_gs_audio_i2s.sv
// Directed self-checking bench for gs_audio_i2s with BCLK_DIV=2 (frame = 256 clk_sys cycles).
// Frames are captured slot by slot at BCK rising edges and compared with hand-derived PCM words.
module tb_gs_audio_i2s;

  localparam logic [63:0] LRCK_PATTERN = 64'hFFFF_FFFF_0000_0000;

  logic       clk_sys = 1'b0;
  logic       areset  = 1'b1;
  logic [8:0] in_l    = 9'd256;
  logic [8:0] in_r    = 9'd256;
  logic       mute    = 1'b0;
  logic       i2s_bck;
  logic       i2s_lrck;
  logic       i2s_data;
  logic       sample_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] cap;
  logic [63:0] lr;
  bit          stable;
  int          c;

  always #5 clk_sys = ~clk_sys;

  gs_audio_i2s #(.BCLK_DIV(2), .AVG_LOG2(4)) dut (
    .clk_sys       (clk_sys),
    .areset        (areset),
    .in_l          (in_l),
    .in_r          (in_r),
    .mute          (mute),
    .i2s_bck       (i2s_bck),
    .i2s_lrck      (i2s_lrck),
    .i2s_data      (i2s_data),
    .sample_strobe (sample_strobe)
  );

  // Expected serial stream indexed by slot: L MSB in slot 1, R MSB in slot 33.
  function automatic logic [63:0] exp_slots(input logic [15:0] l16, input logic [15:0] r16);
    logic [63:0] e;
    e = '0;
    for (int s = 1; s <= 16; s++) begin
      e[s]      = l16[16 - s];
      e[s + 32] = r16[16 - s];
    end
    return e;
  endfunction

  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_sys);
      cycles++;
    end while (!sample_strobe && cycles < 700);
    if (!sample_strobe) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: no sample_strobe within %0d cycles", cycles);
    end
  endtask

  // Records 64 slots starting right after a frame boundary; optionally drives new
  // inputs just after slot change_slot has been sampled.
  task automatic grab_slots(input int change_slot, input logic [8:0] nl,
                            input logic [8:0] nr, input logic nm,
                            output logic [63:0] slots, output logic [63:0] lrck_v,
                            output bit stab);
    logic prev_bck, prev_data, prev_lr;
    int   slot, cyc;
    slots = '0; lrck_v = '0; stab = 1'b1;
    prev_bck = i2s_bck; prev_data = i2s_data; prev_lr = i2s_lrck;
    slot = 0; cyc = 0;
    while (slot < 64 && cyc < 400) begin
      @(negedge clk_sys);
      cyc++;
      if (!prev_bck && i2s_bck) begin
        slots[slot]  = i2s_data;
        lrck_v[slot] = i2s_lrck;
        if (i2s_data !== prev_data || i2s_lrck !== prev_lr) stab = 1'b0;
        if (slot == change_slot) begin
          in_l = nl; in_r = nr; mute = nm;
        end
        slot++;
      end
      prev_bck = i2s_bck; prev_data = i2s_data; prev_lr = i2s_lrck;
    end
    if (slot < 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL grab_timeout: captured %0d of 64 slots", slot);
    end
  endtask

  task automatic test_reset;
    areset = 1'b1; in_l = 9'd256; in_r = 9'd256; mute = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (i2s_bck !== 1'b0) begin n_fail++; $display("FAIL reset_bck: got %b expected 0", i2s_bck); end
    n_checks++;
    if (i2s_lrck !== 1'b0) begin n_fail++; $display("FAIL reset_lrck: got %b expected 0", i2s_lrck); end
    n_checks++;
    if (i2s_data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %b expected 0", i2s_data); end
    n_checks++;
    if (sample_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", sample_strobe); end

    areset = 1'b0;
    c = 0;
    do begin
      @(posedge clk_sys); #1; c++;
    end while (!i2s_bck && c < 50);
    n_checks++;
    if (c !== 2) begin n_fail++; $display("FAIL first_bck_rise: got %0d cycles expected 2", c); end

    c = 0;
    do begin
      @(posedge clk_sys); #1; c++;
    end while (i2s_bck && c < 50);
    do begin
      @(posedge clk_sys); #1; c++;
    end while (!i2s_bck && c < 50);
    n_checks++;
    if (c !== 4) begin n_fail++; $display("FAIL bck_period: got %0d cycles expected 4", c); end
  endtask

  task automatic test_timing;
    wait_strobe(c);
    wait_strobe(c);
    n_checks++;
    if (c !== 256) begin n_fail++; $display("FAIL strobe_period: got %0d cycles expected 256", c); end
    @(negedge clk_sys);
    n_checks++;
    if (sample_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b one cycle later expected 0", sample_strobe); end
  endtask

  task automatic test_extremes;
    in_l = 9'd0; in_r = 9'd510;
    wait_strobe(c);
    wait_strobe(c);
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'h8000, 16'h7F00)) begin
      n_fail++; $display("FAIL extremes_data: got %h expected %h", cap, exp_slots(16'h8000, 16'h7F00));
    end
    n_checks++;
    if (lr !== LRCK_PATTERN) begin n_fail++; $display("FAIL extremes_lrck: got %h expected %h", lr, LRCK_PATTERN); end
  endtask

  task automatic test_midscale;
    in_l = 9'd256; in_r = 9'd257;
    wait_strobe(c);
    wait_strobe(c);
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'h0000, 16'h0080)) begin
      n_fail++; $display("FAIL midscale_data: got %h expected %h", cap, exp_slots(16'h0000, 16'h0080));
    end
    n_checks++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL data_stable_at_rise: got %b expected 1", stable); end
  endtask

  task automatic test_midframe_change;
    // 100-256 = -156 -> 9-bit 0x164 -> <<7 = 0xB200; 400-256 = 144 -> 0x4800.
    in_l = 9'd100; in_r = 9'd256;
    wait_strobe(c);
    wait_strobe(c);
    grab_slots(20, 9'd400, 9'd256, 1'b0, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'hB200, 16'h0000)) begin
      n_fail++; $display("FAIL midframe_current: got %h expected %h", cap, exp_slots(16'hB200, 16'h0000));
    end
    wait_strobe(c);
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'h4800, 16'h0000)) begin
      n_fail++; $display("FAIL midframe_next: got %h expected %h", cap, exp_slots(16'h4800, 16'h0000));
    end
  endtask

  task automatic test_mute;
    in_l = 9'd0; in_r = 9'd0; mute = 1'b1;
    wait_strobe(c);
    wait_strobe(c);
    grab_slots(10, 9'd0, 9'd0, 1'b0, cap, lr, stable);
    n_checks++;
    if (cap !== 64'h0) begin n_fail++; $display("FAIL mute_latched: got %h expected 0", cap); end
    wait_strobe(c);
    grab_slots(10, 9'd0, 9'd0, 1'b1, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'h8000, 16'h8000)) begin
      n_fail++; $display("FAIL unmute_next_frame: got %h expected %h", cap, exp_slots(16'h8000, 16'h8000));
    end
    wait_strobe(c);
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== 64'h0) begin n_fail++; $display("FAIL mute_midframe_next: got %h expected 0", cap); end
    mute = 1'b0;
  endtask

  task automatic test_reset_abort;
    in_l = 9'd0; in_r = 9'd510; mute = 1'b0;
    wait_strobe(c);
    wait_strobe(c);
    repeat (160) @(negedge clk_sys);
    // bit_cnt is now 40: slot 40 carries R bit 8 of 0x7F00.
    n_checks++;
    if ({i2s_lrck, i2s_data} !== 2'b11) begin
      n_fail++; $display("FAIL pre_abort_slot40: got lrck/data %b expected 11", {i2s_lrck, i2s_data});
    end
    areset = 1'b1;
    #1;
    n_checks++;
    if ({i2s_bck, i2s_lrck, i2s_data, sample_strobe} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_outputs: got %b expected 0000", {i2s_bck, i2s_lrck, i2s_data, sample_strobe});
    end
    @(negedge clk_sys);
    areset = 1'b0;
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== 64'h0) begin n_fail++; $display("FAIL post_reset_frame: got %h expected 0", cap); end
    n_checks++;
    if (lr !== LRCK_PATTERN) begin n_fail++; $display("FAIL post_reset_lrck: got %h expected %h", lr, LRCK_PATTERN); end
    wait_strobe(c);
    n_checks++;
    if (c !== 2) begin n_fail++; $display("FAIL post_reset_latch_time: got %0d cycles after slot 63 expected 2", c); end
    grab_slots(-1, in_l, in_r, mute, cap, lr, stable);
    n_checks++;
    if (cap !== exp_slots(16'h8000, 16'h7F00)) begin
      n_fail++; $display("FAIL post_reset_fresh: got %h expected %h", cap, exp_slots(16'h8000, 16'h7F00));
    end
  endtask

`ifdef GS_AUDIO_AVG_EN
  task automatic test_avg;
    int c2;
    in_l = 9'd0; in_r = 9'd256; mute = 1'b0;
    wait_strobe(c);
    fork
      begin
        for (int i = 0; i < 560; i++) begin
          @(negedge clk_sys);
          in_l = i[0] ? 9'd511 : 9'd0;
        end
      end
      begin
        wait_strobe(c2);
        grab_slots(-1, 9'd0, 9'd256, 1'b0, cap, lr, stable);
      end
    join
    // Each 16-cycle window averages 8x0 and 8x511 -> 255 -> 0xFF80.
    n_checks++;
    if (cap !== exp_slots(16'hFF80, 16'h0000)) begin
      n_fail++; $display("FAIL avg_alternating: got %h expected %h", cap, exp_slots(16'hFF80, 16'h0000));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_extremes();
    test_midscale();
    test_midframe_change();
    test_mute();
    test_reset_abort();
`ifdef GS_AUDIO_AVG_EN
    test_avg();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
